// File: rtl/relu_sram_sweeper_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// relu_sram_sweeper_if : single-port SRAM bank pin bundle (cs/we/addr/wdata/rdata)
// Rev 1.0
// ----------------------------------------------------------------------------
interface relu_sram_sweeper_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_cs,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_cs,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/relu_sram_sweeper.sv
`default_nettype none
// ----------------------------------------------------------------------------
// relu_sram_sweeper : in-place FP16 ReLU sweep over a window of a single-port bank
// Rev 1.0
// ----------------------------------------------------------------------------
module relu_sram_sweeper #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              start,
  input  wire logic [ADDR_W-1:0] base_addr,
  input  wire logic [LEN_W-1:0]  len,
  output logic                   busy,
  output logic                   done,
  output logic [LEN_W-1:0]       clamp_cnt,
  relu_sram_sweeper_if.master    mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remain;

  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

  logic              is_nan;
  logic              clamp;
  logic [DATA_W-1:0] relu_out;

  // binary16 layout: sign 15, exponent 14:10, mantissa 9:0
  assign is_nan   = (mem.mem_rdata[14:10] == 5'h1f) && (mem.mem_rdata[9:0] != 10'd0);
  assign clamp    = mem.mem_rdata[DATA_W-1] && !is_nan;
  assign relu_out = clamp ? '0 : mem.mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remain    <= '0;
      clamp_cnt <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= base_addr;
            remain    <= len;
            clamp_cnt <= '0;
          end
        end
        WR: begin
          remain   <= remain - 1'b1;
          cur_addr <= cur_addr + 1'b1;
          if (clamp) begin
            clamp_cnt <= clamp_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    cs         = 1'b0;
    we         = 1'b0;
    addr       = '0;
    wdata      = '0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len == '0) ? DONE : RD;
        end
      end
      RD: begin
        cs         = 1'b1;
        addr       = cur_addr;
        state_next = WR;
      end
      WR: begin
        cs         = 1'b1;
        we         = 1'b1;
        addr       = cur_addr;
        wdata      = relu_out;
        state_next = (remain == LEN_W'(1)) ? DONE : RD;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset blocks the access in flight so a write cannot land on the reset edge.
    if (rst) begin
      cs    = 1'b0;
      we    = 1'b0;
      addr  = '0;
      wdata = '0;
      busy  = 1'b0;
      done  = 1'b0;
    end
  end

  assign mem.mem_cs    = cs;
  assign mem.mem_we    = we;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wdata;

endmodule
`default_nettype wire

// File: tb/tb_relu_sram_sweeper.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_relu_sram_sweeper : directed + randomized checks against a bank/ReLU model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_relu_sram_sweeper;
  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic [LW-1:0] clamp_cnt;

  relu_sram_sweeper_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  relu_sram_sweeper #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .clamp_cnt (clamp_cnt),
    .mem       (mif)
  );

  always #5 clk = ~clk;

  // Bank model: synchronous single-port SRAM plus a preload path used while idle.
  logic [15:0]   bank [DEPTH];
  logic [15:0]   model[DEPTH];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [15:0]   pl_data;
  logic [15:0]   rdata_q;

  assign mif.mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (pl_en) begin
      bank[pl_addr] <= pl_data;
    end else if (mif.mem_cs) begin
      if (mif.mem_we) bank[mif.mem_addr] <= mif.mem_wdata;
      else            rdata_q <= bank[mif.mem_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] relu16(input logic [15:0] x);
    if (x[14:10] == 5'h1f && x[9:0] != 10'd0) return x;
    if (x[15]) return 16'h0000;
    return x;
  endfunction

  function automatic logic [15:0] gen_word();
    logic [15:0] w;
    case ($urandom_range(0, 5))
      0: w = 16'($urandom);
      1: w = 16'h8000;
      2: w = 16'hFC00;
      3: w = {1'($urandom), 5'h1f, 10'($urandom_range(1, 1023))};
      4: w = {1'b0, 15'($urandom)};
      default: w = {1'b1, 15'($urandom_range(0, 16'h7BFF))};
    endcase
    return w;
  endfunction

  // Called at a negedge; consumes one cycle.
  task automatic preload(input logic [AW-1:0] a, input logic [15:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    model[a] = d;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  function automatic int bank_mismatches();
    int m = 0;
    for (int i = 0; i < DEPTH; i++) if (bank[i] !== model[i]) m++;
    return m;
  endfunction

  // Runs one job from a negedge; optionally pulses a conflicting start in glitch_cyc.
  task automatic run_job(input string tag, input logic [AW-1:0] base, input int n,
                         input int glitch_cyc);
    int          exp_done_cyc;
    int          done_cyc;
    int          bus_err;
    int          first_err;
    int          exp_clamp;
    int          limit;
    logic        exp_cs, exp_we, exp_done;
    logic [AW-1:0] exp_addr;
    logic [15:0] exp_wdata;
    logic [AW-1:0] a;

    exp_done_cyc = (n == 0) ? 1 : 2 * n + 1;
    limit        = exp_done_cyc + 6;
    done_cyc     = 0;
    bus_err      = 0;
    first_err    = 0;

    start     = 1'b1;
    base_addr = base;
    len       = LW'(n);
    @(negedge clk);
    start     = 1'b0;
    base_addr = AW'($urandom);
    len       = LW'($urandom);

    for (int cyc = 1; cyc <= limit; cyc++) begin
      exp_cs    = (cyc <= 2 * n);
      exp_we    = exp_cs && (cyc % 2 == 0);
      exp_addr  = exp_cs ? AW'(base + AW'((cyc - 1) / 2)) : '0;
      exp_wdata = exp_we ? relu16(model[exp_addr]) : 16'h0;
      exp_done  = (cyc == exp_done_cyc);
      if (busy !== 1'b1 || mif.mem_cs !== exp_cs || mif.mem_we !== exp_we ||
          mif.mem_addr !== exp_addr || mif.mem_wdata !== exp_wdata || done !== exp_done) begin
        bus_err++;
        if (first_err == 0) first_err = cyc;
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        start    = 1'b0;
        break;
      end
      if (cyc == glitch_cyc) begin
        start     = 1'b1;
        base_addr = base ^ 12'h5A5;
        len       = LW'(n + 3);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;

    exp_clamp = 0;
    for (int k = 0; k < n; k++) begin
      a = AW'(base + AW'(k));
      if (relu16(model[a]) !== model[a]) exp_clamp++;
      model[a] = relu16(model[a]);
    end

    check({tag, "_done_cycle"}, done_cyc, exp_done_cyc);
    check({tag, "_bus_err_first_cycle"}, first_err, 0);
    check({tag, "_clamp_cnt"}, 32'(clamp_cnt), exp_clamp);
    check({tag, "_bank"}, bank_mismatches(), 0);
    @(negedge clk);
    check({tag, "_idle_after"}, {busy, done, mif.mem_cs}, 3'b000);
  endtask

  initial begin
    logic [AW-1:0] rb;
    int            rn;

    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_clamp", clamp_cnt, 0);
    check("reset_bus", {mif.mem_cs, mif.mem_we, mif.mem_addr, mif.mem_wdata}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", {busy, done, mif.mem_cs, mif.mem_we, mif.mem_addr, mif.mem_wdata}, 0);

    for (int i = 0; i < DEPTH; i++) preload(AW'(i), 16'($urandom));

    // Directed example window
    preload(12'h010, 16'h3C00);
    preload(12'h011, 16'hBC00);
    preload(12'h012, 16'h8000);
    preload(12'h013, 16'h7E00);
    run_job("basic", 12'h010, 4, 0);
    check("basic_w0", bank[12'h010], 16'h3C00);
    check("basic_w1", bank[12'h011], 16'h0000);
    check("basic_w2", bank[12'h012], 16'h0000);
    check("basic_w3", bank[12'h013], 16'h7E00);
    check("basic_cnt2", clamp_cnt, 2);

    run_job("len0", 12'h123, 0, 0);

    for (int k = 0; k < 4; k++) preload(AW'(12'hFFE + k), 16'hC000);
    run_job("wrap", 12'hFFE, 4, 0);
    check("wrap_fff", bank[12'hFFF], 16'h0000);
    check("wrap_001", bank[12'h001], 16'h0000);
    check("wrap_cnt4", clamp_cnt, 4);

    for (int k = 0; k < 6; k++) preload(AW'(12'h200 + k), gen_word());
    run_job("busy_start", 12'h200, 6, 3);

    for (int j = 0; j < 8; j++) begin
      rb = AW'($urandom);
      rn = (j == 0) ? 0 : int'($urandom_range(1, 40));
      for (int k = 0; k < rn; k++) preload(AW'(rb + AW'(k)), gen_word());
      run_job($sformatf("rand%0d", j), rb, rn, (j % 3 == 1) ? 2 * rn - 1 : 0);
    end

    // Reset in cycle 4 of a four-word job
    for (int k = 0; k < 4; k++) preload(AW'(12'h300 + k), 16'hC000);
    start = 1'b1; base_addr = 12'h300; len = LW'(4);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rstjob_outputs", {busy, done, mif.mem_cs, mif.mem_we, mif.mem_addr, mif.mem_wdata}, 0);
    check("rstjob_clamp", clamp_cnt, 0);
    @(negedge clk);
    check("rstjob_no_done", {busy, done}, 2'b00);
    model[12'h300] = 16'h0000;
    check("rstjob_w0", bank[12'h300], 16'h0000);
    check("rstjob_w1", bank[12'h301], 16'hC000);
    check("rstjob_bank", bank_mismatches(), 0);

    // Start coincident with reset is dropped
    rst = 1'b1; start = 1'b1; base_addr = 12'h400; len = LW'(2);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_dropped", {busy, done, mif.mem_cs}, 3'b000);

    for (int i = 0; i < DEPTH; i++) preload(AW'(i), (i % 2 == 0) ? 16'h4000 : 16'hC000);
    run_job("full", 12'h000, DEPTH, 0);
    check("full_cnt2048", clamp_cnt, 2048);
    repeat (3) @(negedge clk);
    check("full_cnt_hold", clamp_cnt, 2048);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
